// File: rtl/tick_sched.sv
// rtl/tick_sched.sv - programmable prescaler tick scheduler with periodic and one-shot runs
module tick_sched #(
  parameter int               DIV_W       = 20,
  parameter int               CNT_W       = 8,
  parameter logic [DIV_W-1:0] DEFAULT_DIV = 20'hFFFFF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             cfg_mode,
  input  logic [CNT_W-1:0] cfg_ticks,
  input  logic             cfg_load,
  input  logic             start,
  input  logic             stop,
  output logic             tick,
  output logic             slow_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t             state, state_n;
  logic [DIV_W-1:0]   div_reg, div_n;
  logic               mode_reg, mode_n;
  logic [CNT_W-1:0]   ticks_reg, ticks_n;
  logic [DIV_W-1:0]   pre, pre_n;
  logic [CNT_W-1:0]   remaining, remaining_n;
  logic               tick_n, slow_n, busy_n, done_n;

  // State, configuration, prescaler and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      div_reg   <= DEFAULT_DIV;
      mode_reg  <= 1'b0;
      ticks_reg <= '0;
      pre       <= '0;
      remaining <= '0;
      tick      <= 1'b0;
      slow_out  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      div_reg   <= div_n;
      mode_reg  <= mode_n;
      ticks_reg <= ticks_n;
      pre       <= pre_n;
      remaining <= remaining_n;
      tick      <= tick_n;
      slow_out  <= slow_n;
      busy      <= busy_n;
      done      <= done_n;
    end
  end

  // Next-state and next-output decode; tick and done are single-cycle by default.
  always_comb begin
    state_n     = state;
    div_n       = div_reg;
    mode_n      = mode_reg;
    ticks_n     = ticks_reg;
    pre_n       = pre;
    remaining_n = remaining;
    tick_n      = 1'b0;
    slow_n      = slow_out;
    busy_n      = busy;
    done_n      = 1'b0;

    case (state)
      IDLE: begin
        // A load coincident with start takes effect for that start.
        if (cfg_load) begin
          div_n   = cfg_div;
          mode_n  = cfg_mode;
          ticks_n = cfg_ticks;
        end
        if (start && !stop) begin
          if (mode_n && (ticks_n == '0)) begin
            state_n = FINISH;
            done_n  = 1'b1;
            busy_n  = 1'b0;
          end else begin
            state_n     = RUN;
            pre_n       = '0;
            remaining_n = ticks_n;
            busy_n      = 1'b1;
          end
        end
      end

      RUN: begin
        if (stop) begin
          // Abort beats a coincident terminal count: no tick, no done.
          state_n = IDLE;
          pre_n   = '0;
          slow_n  = 1'b0;
          busy_n  = 1'b0;
        end else if (pre == div_reg) begin
          pre_n  = '0;
          tick_n = 1'b1;
          slow_n = ~slow_out;
          if (mode_reg) begin
            if (remaining == CNT_W'(1)) begin
              state_n     = FINISH;
              busy_n      = 1'b0;
              done_n      = 1'b1;
              remaining_n = '0;
            end else begin
              remaining_n = remaining - CNT_W'(1);
            end
          end
        end else begin
          pre_n = pre + DIV_W'(1);
        end
      end

      FINISH: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end

      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_tick_sched.sv
// tb/tb_tick_sched.sv - directed self-checking bench for tick_sched
module tb_tick_sched;

  logic        clk;
  logic        rst_n;
  logic [19:0] cfg_div;
  logic        cfg_mode;
  logic [7:0]  cfg_ticks;
  logic        cfg_load;
  logic        start;
  logic        stop;
  logic        tick;
  logic        slow_out;
  logic        busy;
  logic        done;

  int checks;
  int failures;

  tick_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_div   (cfg_div),
    .cfg_mode  (cfg_mode),
    .cfg_ticks (cfg_ticks),
    .cfg_load  (cfg_load),
    .start     (start),
    .stop      (stop),
    .tick      (tick),
    .slow_out  (slow_out),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [19:0] d, input logic m, input logic [7:0] t);
    cfg_div  = d;
    cfg_mode = m;
    cfg_ticks = t;
    cfg_load = 1'b1;
    cyc();
    cfg_load = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    cfg_div = '0;
    cfg_mode = 1'b0;
    cfg_ticks = '0;
    cfg_load = 1'b0;
    start = 1'b0;
    stop = 1'b0;

    // Reset state
    cyc();
    cyc();
    check("rst_tick", tick, 0);
    check("rst_slow", slow_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;
    cyc();

    // 1: periodic, div=3 -> tick every 4 cycles
    load(20'd3, 1'b0, 8'd0);
    pulse_start();
    check("t1_busy_after_start", busy, 1);
    check("t1_tick_after_start", tick, 0);
    for (int k = 1; k <= 12; k++) begin
      cyc();
      check($sformatf("t1_tick_k%0d", k), tick, (k % 4 == 0) ? 1 : 0);
      check($sformatf("t1_slow_k%0d", k), slow_out, (k / 4) % 2);
      check($sformatf("t1_busy_k%0d", k), busy, 1);
    end
    pulse_stop();
    check("t1_stop_busy", busy, 0);
    check("t1_stop_slow", slow_out, 0);
    check("t1_stop_tick", tick, 0);

    // 2: one-shot div=1, 3 ticks -> ticks at +2,+4,+6, done with the third
    load(20'd1, 1'b1, 8'd3);
    pulse_start();
    for (int k = 1; k <= 9; k++) begin
      cyc();
      check($sformatf("t2_tick_k%0d", k), tick, (k == 2 || k == 4 || k == 6) ? 1 : 0);
      check($sformatf("t2_done_k%0d", k), done, (k == 6) ? 1 : 0);
      check($sformatf("t2_busy_k%0d", k), busy, (k < 6) ? 1 : 0);
    end
    check("t2_slow_end", slow_out, 1);

    // 3: one-shot with zero budget, loaded in the same cycle as start
    cfg_div = 20'd2;
    cfg_mode = 1'b1;
    cfg_ticks = 8'd0;
    cfg_load = 1'b1;
    start = 1'b1;
    cyc();
    cfg_load = 1'b0;
    start = 1'b0;
    check("t3_done", done, 1);
    check("t3_busy", busy, 0);
    check("t3_tick", tick, 0);
    cyc();
    check("t3_done_clear", done, 0);
    check("t3_busy_idle", busy, 0);
    cyc();
    check("t3_tick_idle", tick, 0);

    // 4: periodic div=4, stop in the cycle where pre==4
    load(20'd4, 1'b0, 8'd0);
    pulse_start();
    for (int k = 1; k <= 4; k++) begin
      cyc();
      check($sformatf("t4_tick_k%0d", k), tick, 0);
    end
    check("t4_slow_before_stop", slow_out, 1);
    pulse_stop();
    check("t4_stop_tick", tick, 0);
    check("t4_stop_busy", busy, 0);
    check("t4_stop_slow", slow_out, 0);
    cyc();
    check("t4_idle_tick", tick, 0);
    pulse_start();
    for (int k = 1; k <= 5; k++) begin
      cyc();
      check($sformatf("t4_restart_tick_k%0d", k), tick, (k == 5) ? 1 : 0);
    end
    pulse_stop();

    // 5: div=2; load and start mid-run are ignored
    load(20'd2, 1'b0, 8'd0);
    pulse_start();
    for (int k = 1; k <= 12; k++) begin
      cfg_div  = 20'd9;
      cfg_load = (k == 4) ? 1'b1 : 1'b0;
      start    = (k == 7) ? 1'b1 : 1'b0;
      cyc();
      check($sformatf("t5_tick_k%0d", k), tick, (k % 3 == 0) ? 1 : 0);
    end
    cfg_load = 1'b0;
    start = 1'b0;
    pulse_stop();
    load(20'd9, 1'b0, 8'd0);
    pulse_start();
    for (int k = 1; k <= 20; k++) begin
      cyc();
      check($sformatf("t5_div9_tick_k%0d", k), tick, (k % 10 == 0) ? 1 : 0);
    end
    pulse_stop();

    // 6: one-shot div=0, 5 ticks; reset after the second tick
    load(20'd0, 1'b1, 8'd5);
    pulse_start();
    cyc();
    check("t6_tick1", tick, 1);
    check("t6_slow1", slow_out, 1);
    cyc();
    check("t6_tick2", tick, 1);
    check("t6_busy2", busy, 1);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    check("t6_rst_tick", tick, 0);
    check("t6_rst_slow", slow_out, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_done", done, 0);
    check("t6_rst_div", dut.div_reg, 32'h000FFFFF);
    for (int k = 1; k <= 6; k++) begin
      cyc();
      check($sformatf("t6_post_done_k%0d", k), done, 0);
      check($sformatf("t6_post_tick_k%0d", k), tick, 0);
    end
    // Reset divisor is huge and mode is periodic: a run shows no tick for a long while.
    pulse_start();
    check("t6_default_busy", busy, 1);
    for (int k = 1; k <= 30; k++) begin
      cyc();
      check($sformatf("t6_default_tick_k%0d", k), tick, 0);
    end
    pulse_stop();
    check("t6_default_stop_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tick_sched.md
Name: tick_sched

Overview:
- Synchronous, programmable tick scheduler that sequences the clock-division datapath.
- Replaces free-running ripple division with a single-clock prescaler whose terminal count, run mode and tick budget are set by a controller.
- Emits single-cycle tick enables plus a divided square wave (slow_out) for downstream logic (display scan, debounce, timers). All downstream logic stays on clk.
- Supports periodic and one-shot operation with start/stop control and a done pulse.

Parameters:
- DIV_W, 20: prescaler and divisor width.
- CNT_W, 8: one-shot tick-budget width.
- DEFAULT_DIV, 20'hFFFFF: divisor loaded at reset.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous reset, active-low.
- cfg_div  in  DIV_W  terminal count; tick period = cfg_div+1 cycles.
- cfg_mode  in  1  0 = periodic, 1 = one-shot.
- cfg_ticks  in  CNT_W  tick count for one-shot mode.
- cfg_load  in  1  pulse; latches cfg_div/cfg_mode/cfg_ticks.
- start  in  1  pulse; begin run.
- stop  in  1  pulse; abort run.
- tick  out  1  one-cycle enable per elapsed period.
- slow_out  out  1  toggles on every tick.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse at one-shot completion.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low.
- Reset (rst_n=0 at edge): state=IDLE, div_reg=DEFAULT_DIV, mode_reg=0, ticks_reg=0, pre=0, remaining=0, tick=0, slow_out=0, busy=0, done=0. Applies mid-run; no done is generated.
- All outputs are registered.
- FSM states: IDLE, RUN, FINISH.
- IDLE:
  - cfg_load=1: latch div_reg, mode_reg, ticks_reg.
  - start=1 and stop=0: if mode_reg=1 and ticks_reg=0, go to FINISH. Otherwise go to RUN with pre=0, remaining=ticks_reg, busy=1.
  - cfg_load and start in the same cycle: latch first; start uses the new values.
- RUN, each cycle:
  - If pre==div_reg: pre<=0, tick<=1, slow_out<=~slow_out. Otherwise pre<=pre+1, tick<=0.
  - First tick is asserted in the cycle beginning div_reg+1 edges after the start edge. Subsequent ticks occur every div_reg+1 cycles.
  - div_reg=0 gives tick high every cycle, and slow_out toggles every cycle.
- One-shot (mode_reg=1):
  - remaining decrements on each tick-producing edge.
  - The edge producing the tick with remaining==1 also sets state=FINISH, busy=0, done=1. tick and done are high in the same cycle.
- Periodic (mode_reg=0): runs until stop. remaining is unused.
- FINISH: lasts exactly one cycle with done=1, then returns to IDLE with done=0. start in FINISH is ignored.
- stop=1 in RUN: next edge state=IDLE, pre=0, tick=0, slow_out=0, busy=0, no done.
  - stop wins over a coincident terminal count: no tick is emitted.
  - stop wins over a coincident start.
- Ignored inputs:
  - cfg_load is ignored in RUN and FINISH; the run continues with latched values.
  - start is ignored in RUN (no restart).
  - stop is ignored in IDLE and FINISH.
- pre never exceeds div_reg, so no wrap occurs. remaining never underflows because FINISH is entered at 1.

Test Plan:
1. Reset, then load cfg_div=3, mode=0, then start. Required: tick high on cycles 4, 8, 12… after the start edge; slow_out toggles at each tick; busy=1 from the edge after start.
2. Load cfg_div=1, mode=1, cfg_ticks=3, then start. Required: ticks at +2, +4, +6; done=1 coincident with the third tick; busy=0 that cycle; back in IDLE one cycle later with no further ticks.
3. Load mode=1, cfg_ticks=0, then start. Required: no tick; done pulses one cycle after the start edge; busy stays 0.
4. Periodic run with cfg_div=4; assert stop in the cycle where pre==4. Required: no tick; next cycle busy=0, slow_out=0; start issued later restarts with the first tick at +5.
5. Run with cfg_div=2; pulse cfg_load with cfg_div=9 mid-run, then pulse start again. Required: period stays 3 cycles, no restart. After stop then start, period becomes 10.
6. One-shot cfg_div=0, cfg_ticks=5; drop rst_n after the 2nd tick. Required: all outputs 0 at the next edge, no done, div_reg returns to 20'hFFFFF.
